// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for mem_ctrl: FSM state encoding, LS_size codes,
// IO window bounds and the byte-count helper.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    IF_RD = 2'd1,
    LS_RD = 2'd2,
    LS_WR = 2'd3
  } state_e;

  typedef enum logic {
    GNT_IF = 1'b0,
    GNT_LS = 1'b1
  } port_e;

  localparam logic [1:0]  SIZE_B     = 2'b00;
  localparam logic [1:0]  SIZE_H     = 2'b01;
  localparam logic [1:0]  SIZE_W     = 2'b10;
  localparam logic [31:0] IO_ADDR_LO = 32'h0003_0000;
  localparam logic [31:0] IO_ADDR_HI = 32'h0003_0007;

  function automatic logic [2:0] size_to_n(input logic [1:0] size);
    case (size)
      SIZE_B:  return 3'd1;
      SIZE_H:  return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Byte-serial memory arbiter between instruction fetch and load/store ports.
// Optional MEM_CTRL_IO_STALL_EN: stores into the IO window wait on io_buffer_full.
module mem_ctrl
  import mem_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        roll_back,
  input  logic        IF_req,
  input  logic [31:0] IF_addr,
  output logic        IF_done,
  output logic [31:0] IF_data,
  input  logic        LS_req,
  input  logic        LS_wr,
  input  logic [1:0]  LS_size,
  input  logic [31:0] LS_addr,
  input  logic [31:0] LS_wdata,
  output logic        LS_done,
  output logic [31:0] LS_rdata,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full
);

  state_e      state_q, state_d;
  port_e       lg_q, lg_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [2:0]  n_q, n_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] buf_q, buf_d;
  logic        if_done_d, ls_done_d;
  logic [31:0] if_data_d, ls_rdata_d;
  logic        if_ok, ls_ok, io_stall;
  logic [1:0]  cap_idx;

  // A port whose done is showing still has req high; it must not be re-granted.
  assign if_ok   = IF_req && !IF_done;
  assign ls_ok   = LS_req && !LS_done;
  assign cap_idx = cnt_q[1:0] - 2'd1;

`ifdef MEM_CTRL_IO_STALL_EN
  assign io_stall = io_buffer_full && (addr_q >= IO_ADDR_LO) && (addr_q <= IO_ADDR_HI);
`else
  logic unused_io;
  assign unused_io = io_buffer_full;
  assign io_stall  = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    lg_d       = lg_q;
    cnt_d      = cnt_q;
    n_d        = n_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    buf_d      = buf_q;
    if_done_d  = 1'b0;
    ls_done_d  = 1'b0;
    if_data_d  = IF_data;
    ls_rdata_d = LS_rdata;
    mem_a      = '0;
    mem_dout   = '0;
    mem_wr     = 1'b0;

    case (state_q)
      IDLE: begin
        if (!roll_back && (if_ok || ls_ok)) begin
          cnt_d = '0;
          buf_d = '0;
          if (ls_ok && (!if_ok || lg_q == GNT_IF)) begin
            state_d = LS_wr ? LS_WR : LS_RD;
            lg_d    = GNT_LS;
            addr_d  = LS_addr;
            wdata_d = LS_wdata;
            n_d     = size_to_n(LS_size);
          end else begin
            state_d = IF_RD;
            lg_d    = GNT_IF;
            addr_d  = IF_addr;
            n_d     = 3'd4;
          end
        end
      end

      IF_RD, LS_RD: begin
        if (cnt_q < n_q) mem_a = addr_q + {29'd0, cnt_q};
        // RAM answers one cycle late, so byte cnt-1 is on mem_din now.
        if (cnt_q != 3'd0) buf_d[{cap_idx, 3'b000} +: 8] = mem_din;
        if (roll_back) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == n_q) begin
          state_d = IDLE;
          cnt_d   = '0;
          if (state_q == IF_RD) begin
            if_done_d = 1'b1;
            if_data_d = buf_d;
          end else begin
            ls_done_d  = 1'b1;
            ls_rdata_d = buf_d;
          end
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end

      LS_WR: begin
        mem_a    = addr_q + {29'd0, cnt_q};
        mem_dout = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
        mem_wr   = rdy && !io_stall;
        // Committed store: roll_back deliberately not consulted here.
        if (!io_stall) begin
          if (cnt_q == n_q - 3'd1) begin
            state_d   = IDLE;
            cnt_d     = '0;
            ls_done_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      lg_q     <= GNT_IF;
      cnt_q    <= '0;
      n_q      <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      buf_q    <= '0;
      IF_done  <= 1'b0;
      LS_done  <= 1'b0;
      IF_data  <= '0;
      LS_rdata <= '0;
    end else if (rdy) begin
      state_q  <= state_d;
      lg_q     <= lg_d;
      cnt_q    <= cnt_d;
      n_q      <= n_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      buf_q    <= buf_d;
      IF_done  <= if_done_d;
      LS_done  <= ls_done_d;
      IF_data  <= if_data_d;
      LS_rdata <= ls_rdata_d;
    end
  end

endmodule
